bus_master_if: RTL and testbench
================================

BUS_MASTER_IF -- requirements
Module: bus_master_if

Interface
REQ-001 Parameter STALL_BIT, default 1, index of stall_i bit this port obeys (1 = fetch port, 4 = memory port).
REQ-002 Parameter TIMEOUT, default 255, max BUSY cycles without ack/err before abort (8-bit counter).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 stall_i  in  6  pipeline stall vector from pipeline control; bit STALL_BIT = 1 holds the consuming stage.
REQ-006 flush_i  in  1  exception flush from pipeline control.
REQ-007 cpu_ce_i, cpu_we_i  in  1 each  CPU access request / write enable.
REQ-008 cpu_addr_i, cpu_data_i  in  32 each  CPU address / write data.
REQ-009 cpu_sel_i  in  4  byte selects.
REQ-010 cpu_data_o  out  32  read data to pipeline.
REQ-011 stallreq  out  1  stall request to pipeline control (1 = stop).
REQ-012 bus_err_o  out  1  one-cycle pulse on timeout or bus error abort.
REQ-013 wb_adr_o, wb_dat_o  out  32 each; wb_sel_o out 4; wb_we_o, wb_stb_o, wb_cyc_o out 1 each (Wishbone classic master).
REQ-014 wb_dat_i  in  32; wb_ack_i, wb_err_i  in  1 each.

Function
REQ-015 States SHALL be IDLE, BUSY, WAIT_STALL; encoded 2 bits, unused code returns to IDLE.
REQ-016 IDLE: if cpu_ce_i=1 and flush_i=0, next edge SHALL register addr/data/we/sel onto wb_*_o, assert wb_stb_o=wb_cyc_o=1, clear timeout counter, enter BUSY.
REQ-017 BUSY, wb_ack_i=1: next edge SHALL drop stb/cyc/we, zero sel, latch wb_dat_i into rd_buf; go WAIT_STALL if stall_i[STALL_BIT]=1 else IDLE.
REQ-018 BUSY, wb_err_i=1 or counter = TIMEOUT (no ack): next edge SHALL drop stb/cyc, zero rd_buf, pulse bus_err_o high exactly one cycle, go IDLE.
REQ-019 BUSY, flush_i=1: next edge SHALL drop stb/cyc, zero rd_buf, go IDLE, no bus_err_o; flush outranks ack, err, timeout.
REQ-020 BUSY counter SHALL increment each cycle without ack/err and saturate at TIMEOUT.
REQ-021 WAIT_STALL: stall_i[STALL_BIT]=0 or flush_i=1 SHALL return to IDLE next edge; wb_* idle throughout.
REQ-022 stallreq (combinational): IDLE = cpu_ce_i & ~flush_i; BUSY = 0 when ack, err, timeout or flush this cycle, else 1; WAIT_STALL = 0.
REQ-023 cpu_data_o (combinational): BUSY with ack and cpu_we_i=0 -> wb_dat_i; WAIT_STALL -> rd_buf; all other cases 0.
REQ-024 Ack and err asserted together SHALL be treated as err.
REQ-025 A new access SHALL never start in the same cycle the previous one completes; min one IDLE cycle between accesses.
REQ-026 Write accesses SHALL complete identically but return cpu_data_o=0.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, counter=0, rd_buf=0, bus_err_o=0, wb_stb_o=wb_cyc_o=wb_we_o=0, wb_sel_o=0, wb_adr_o=wb_dat_o=0.
REQ-028 Reset mid-BUSY SHALL drop stb/cyc asynchronously without bus_err_o; late ack after release SHALL be ignored in IDLE.
REQ-029 During reset stallreq=0 and cpu_data_o=0.

Verification
REQ-030 Read: ce=1, addr=0x100, ack on 3rd BUSY cycle with wb_dat_i=0xDEADBEEF, stall_i=0 -> stallreq 1 until ack cycle, cpu_data_o=0xDEADBEEF in ack cycle, stb/cyc low next cycle.
REQ-031 Read + hold: as above with stall_i[STALL_BIT]=1 for 4 cycles after ack -> WAIT_STALL, cpu_data_o=0xDEADBEEF, stallreq=0 each cycle, IDLE after release.
REQ-032 Flush: flush_i=1 in 2nd BUSY cycle with ack same cycle -> stallreq=0, cpu_data_o=0, IDLE next edge, bus_err_o stays 0.
REQ-033 Timeout: TIMEOUT=4, no ack -> stb/cyc high 5 cycles, bus_err_o one-cycle pulse, cpu_data_o=0, IDLE.
REQ-034 Write: we=1, sel=4'b0011, data=0x12345678 -> wb_we_o=1, wb_sel_o=0011, wb_dat_o=0x12345678 until ack, cpu_data_o=0.
REQ-035 Async reset: rst low mid-BUSY between clock edges -> stb/cyc low before next edge, IDLE after release.

Source files
------------

// File: rtl/bus_master_if.sv
// bus_master_if: Wishbone classic master for one pipeline port (fetch or memory).
// Runs one CPU access at a time on the bus, stalls the pipeline while it is in
// flight, and holds read data while the consuming stage is stalled.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   stall_i[5:0], flush_i    pipeline control (bit STALL_BIT holds our consumer)
//   cpu_ce_i/we_i/addr_i/data_i/sel_i   CPU access request
//   cpu_data_o, stallreq     combinational read data / stall request to pipeline
//   bus_err_o                one-cycle pulse on bus error or timeout abort
//   wb_*                     Wishbone classic master signals
module bus_master_if #(
  parameter int unsigned STALL_BIT = 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq,
  output logic        bus_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    BUSY       = 2'b01,
    WAIT_STALL = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    rd_buf_q, rd_buf_d;
  logic [DW-1:0]    adr_q, adr_d;
  logic [DW-1:0]    dat_q, dat_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic             we_q, we_d;
  logic             stb_q, stb_d;
  logic             bus_err_q, bus_err_d;

  logic hold_stage;
  logic timeout;
  logic unused_stall;

  assign hold_stage   = stall_i[STALL_BIT];
  assign unused_stall = ^stall_i;
  // Timeout only fires when the slave has not answered this cycle.
  assign timeout      = (cnt_q == TO_VAL) && !wb_ack_i && !wb_err_i;

  // State and bus register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_buf_q  <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      stb_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_buf_q  <= rd_buf_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      stb_q     <= stb_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state, bus control and combinational pipeline outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_buf_d   = rd_buf_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    stb_d      = stb_q;
    bus_err_d  = 1'b0;
    stallreq   = 1'b0;
    cpu_data_o = '0;

    case (state_q)
      IDLE: begin
        stallreq = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          adr_d   = cpu_addr_i;
          dat_d   = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Priority: flush > err (also covers ack+err) > ack > timeout.
        if (flush_i) begin
          stb_d    = 1'b0;
          we_d     = 1'b0;
          sel_d    = '0;
          rd_buf_d = '0;
          state_d  = IDLE;
        end else if (wb_err_i || timeout) begin
          stb_d     = 1'b0;
          we_d      = 1'b0;
          sel_d     = '0;
          rd_buf_d  = '0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else if (wb_ack_i) begin
          stb_d      = 1'b0;
          we_d       = 1'b0;
          sel_d      = '0;
          // Writes keep the buffer clear so a held write returns zero.
          rd_buf_d   = we_q ? '0 : wb_dat_i;
          cpu_data_o = cpu_we_i ? '0 : wb_dat_i;
          state_d    = hold_stage ? WAIT_STALL : IDLE;
        end else begin
          stallreq = 1'b1;
          if (cnt_q < TO_VAL) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf_q;
        if (!hold_stage || flush_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pipeline sees a quiet port while reset is held.
    if (!rst) begin
      stallreq   = 1'b0;
      cpu_data_o = '0;
    end
  end

  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = stb_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: self-checking bench for bus_master_if (STALL_BIT=1, TIMEOUT=4).
// Transactions are described by their bus response timing; expected pipeline and
// bus behaviour is derived per transaction from those parameters.
module tb_bus_master_if;

  localparam int unsigned SB = 1;
  localparam int unsigned TO = 4;

  logic        clk, rst;
  logic [5:0]  stall_i;
  logic        flush_i, cpu_ce_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]  cpu_sel_i, wb_sel_o;
  logic        stallreq, bus_err_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i;

  int tests_run    = 0;
  int tests_failed = 0;
  bit exp_err_pulse = 1'b0;

  bus_master_if #(.STALL_BIT(SB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq(stallreq), .bus_err_o(bus_err_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stall vector with random noise on bits this port must ignore.
  function automatic logic [5:0] stall_vec(input logic hold);
    logic [5:0] v;
    v = 6'($urandom);
    v[SB] = hold;
    return v;
  endfunction

  // One access: ack_at = BUSY cycle index of ack/err (beyond TO means silent slave),
  // flush_at = BUSY cycle index of flush (-1 none), hold = stall cycles after ack.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, input logic [31:0] rdata, input int ack_at,
                         input bit err, input int flush_at, input int hold);
    int  k;
    int  outcome;  // 0 flush, 1 abort, 2 ack
    bit  done, is_fl, is_rsp, fin;
    logic [31:0] exp_data;
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = data; cpu_sel_i = sel;
    flush_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
    stall_i = stall_vec(1'b0);
    #1;
    tests_run++; if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0) begin tests_failed++; $display("FAIL idle_stb got %b/%b exp 0/0", wb_stb_o, wb_cyc_o); end
    tests_run++; if (wb_we_o !== 1'b0 || wb_sel_o !== 4'h0) begin tests_failed++; $display("FAIL idle_we_sel got %b/%h exp 0/0", wb_we_o, wb_sel_o); end
    tests_run++; if (bus_err_o !== exp_err_pulse) begin tests_failed++; $display("FAIL idle_bus_err got %b exp %b", bus_err_o, exp_err_pulse); end
    tests_run++; if (stallreq !== 1'b1) begin tests_failed++; $display("FAIL idle_stallreq got %b exp 1", stallreq); end
    tests_run++; if (cpu_data_o !== 32'h0) begin tests_failed++; $display("FAIL idle_data got %h exp 0", cpu_data_o); end
    exp_err_pulse = 1'b0;
    tick();
    k = 0; done = 1'b0; outcome = 0;
    while (!done) begin
      is_fl  = (k == flush_at);
      is_rsp = (k == ack_at);
      fin    = is_fl || is_rsp || (k == int'(TO));
      flush_i  = is_fl;
      wb_err_i = is_rsp && err;
      wb_ack_i = is_rsp && (err ? 1'($urandom_range(0, 1)) : 1'b1);
      wb_dat_i = is_rsp ? rdata : $urandom;
      stall_i  = stall_vec(hold > 0);
      exp_data = (is_rsp && !err && !is_fl && !we) ? rdata : 32'h0;
      #1;
      tests_run++; if (wb_stb_o !== 1'b1 || wb_cyc_o !== 1'b1) begin tests_failed++; $display("FAIL busy_stb k=%0d got %b/%b exp 1/1", k, wb_stb_o, wb_cyc_o); end
      tests_run++; if (wb_adr_o !== addr || wb_we_o !== we || wb_sel_o !== sel) begin tests_failed++; $display("FAIL busy_req k=%0d got %h/%b/%h exp %h/%b/%h", k, wb_adr_o, wb_we_o, wb_sel_o, addr, we, sel); end
      if (we) begin
        tests_run++; if (wb_dat_o !== data) begin tests_failed++; $display("FAIL busy_wdat k=%0d got %h exp %h", k, wb_dat_o, data); end
      end
      tests_run++; if (bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL busy_bus_err k=%0d got %b exp 0", k, bus_err_o); end
      tests_run++; if (stallreq !== !fin) begin tests_failed++; $display("FAIL busy_stallreq k=%0d got %b exp %b", k, stallreq, !fin); end
      tests_run++; if (cpu_data_o !== exp_data) begin tests_failed++; $display("FAIL busy_data k=%0d got %h exp %h", k, cpu_data_o, exp_data); end
      if (fin) begin
        done = 1'b1;
        outcome = is_fl ? 0 : ((is_rsp && !err) ? 2 : 1);
      end
      tick();
      k++;
      if (k > int'(TO) + 2) begin
        tests_run++; tests_failed++; $display("FAIL busy_budget k=%0d exp end by %0d", k, TO);
        done = 1'b1;
      end
    end
    flush_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
    if (outcome == 2) begin
      for (int i = 0; i < hold; i++) begin
        stall_i = stall_vec(i < hold - 1);
        #1;
        tests_run++; if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0) begin tests_failed++; $display("FAIL hold_stb i=%0d got %b/%b exp 0/0", i, wb_stb_o, wb_cyc_o); end
        tests_run++; if (stallreq !== 1'b0) begin tests_failed++; $display("FAIL hold_stallreq i=%0d got %b exp 0", i, stallreq); end
        tests_run++; if (cpu_data_o !== (we ? 32'h0 : rdata)) begin tests_failed++; $display("FAIL hold_data i=%0d got %h exp %h", i, cpu_data_o, (we ? 32'h0 : rdata)); end
        tick();
      end
    end
    stall_i = stall_vec(1'b0);
    exp_err_pulse = (outcome == 1);
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_ce_i = 1'b1; cpu_we_i = 1'b1; flush_i = 1'b0; stall_i = 6'h3f;
    cpu_addr_i = 32'h55; cpu_data_i = 32'h66; cpu_sel_i = 4'hf;
    wb_ack_i = 1'b1; wb_err_i = 1'b0; wb_dat_i = 32'hffff_ffff;
    #2;
    repeat (2) tick();
    tests_run++; if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0 || wb_we_o !== 1'b0) begin tests_failed++; $display("FAIL rst_ctrl got %b/%b/%b exp 0/0/0", wb_stb_o, wb_cyc_o, wb_we_o); end
    tests_run++; if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || wb_sel_o !== 4'h0) begin tests_failed++; $display("FAIL rst_bus got %h/%h/%h exp 0/0/0", wb_adr_o, wb_dat_o, wb_sel_o); end
    tests_run++; if (stallreq !== 1'b0 || cpu_data_o !== 32'h0 || bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL rst_cpu got %b/%h/%b exp 0/0/0", stallreq, cpu_data_o, bus_err_o); end
    cpu_ce_i = 1'b0; wb_ack_i = 1'b0; stall_i = 6'h0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read();
    run_txn(1'b0, 32'h100, 32'h0, 4'hf, 32'hDEADBEEF, 2, 1'b0, -1, 0);
  endtask

  task automatic test_read_hold();
    run_txn(1'b0, 32'h100, 32'h0, 4'hf, 32'hDEADBEEF, 2, 1'b0, -1, 4);
  endtask

  task automatic test_write();
    run_txn(1'b1, 32'h200, 32'h12345678, 4'b0011, 32'hCAFEF00D, 1, 1'b0, -1, 2);
  endtask

  task automatic test_flush();
    run_txn(1'b0, 32'h300, 32'h0, 4'hf, 32'hA5A5A5A5, 1, 1'b0, 1, 0);
    // Flush while idle blocks a new request.
    cpu_ce_i = 1'b1; flush_i = 1'b1; cpu_addr_i = 32'h400;
    #1;
    tests_run++; if (stallreq !== 1'b0) begin tests_failed++; $display("FAIL idle_flush_stallreq got %b exp 0", stallreq); end
    tests_run++; if (bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL idle_flush_err got %b exp 0", bus_err_o); end
    tick();
    tests_run++; if (wb_stb_o !== 1'b0) begin tests_failed++; $display("FAIL idle_flush_stb got %b exp 0", wb_stb_o); end
    flush_i = 1'b0;
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'h500, 32'h0, 4'hf, 32'h11111111, 99, 1'b0, -1, 0);
    run_txn(1'b1, 32'h504, 32'h77, 4'h1, 32'h22222222, 4, 1'b0, -1, 0);
  endtask

  task automatic test_err();
    run_txn(1'b0, 32'h600, 32'h0, 4'hf, 32'h33333333, 0, 1'b1, -1, 2);
    run_txn(1'b0, 32'h604, 32'h0, 4'hf, 32'h44444444, 3, 1'b1, 3, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), $urandom,
              $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1,
              $urandom_range(0, 3));
    end
  endtask

  task automatic test_async_reset();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h700; cpu_sel_i = 4'hf;
    flush_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; stall_i = stall_vec(1'b0);
    tick();
    tick();
    tests_run++; if (wb_stb_o !== 1'b1) begin tests_failed++; $display("FAIL arst_pre_stb got %b exp 1", wb_stb_o); end
    #2 rst = 1'b0;
    #1;
    tests_run++; if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0) begin tests_failed++; $display("FAIL arst_stb got %b/%b exp 0/0", wb_stb_o, wb_cyc_o); end
    tests_run++; if (bus_err_o !== 1'b0 || stallreq !== 1'b0 || cpu_data_o !== 32'h0) begin tests_failed++; $display("FAIL arst_cpu got %b/%b/%h exp 0/0/0", bus_err_o, stallreq, cpu_data_o); end
    tests_run++; if (wb_adr_o !== 32'h0) begin tests_failed++; $display("FAIL arst_adr got %h exp 0", wb_adr_o); end
    @(negedge clk);
    #1;
    rst = 1'b1; cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hBADC0DE5;
    #1;
    tests_run++; if (cpu_data_o !== 32'h0) begin tests_failed++; $display("FAIL late_ack_data got %h exp 0", cpu_data_o); end
    tick();
    tests_run++; if (wb_stb_o !== 1'b0 || bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL late_ack_idle got %b/%b exp 0/0", wb_stb_o, bus_err_o); end
    wb_ack_i = 1'b0;
    exp_err_pulse = 1'b0;
    run_txn(1'b0, 32'h800, 32'h0, 4'hf, 32'h0BADF00D, 1, 1'b0, -1, 1);
  endtask

  initial begin
    test_reset();
    test_read();
    test_read_hold();
    test_write();
    test_flush();
    test_timeout();
    test_err();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
